// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-ported synchronous RAM between the fetch and
//            data ports, steering read data back through a tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam logic [3:0]  c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [15:0] c_CNT_MAX      = 16'hFFFF;
    localparam int          c_TAIL         = READ_LATENCY - 1;

    logic [3:0]              r_starve_q;
    logic [3:0]              w_starve_d;
    logic [15:0]             r_conflict_q;
    logic [15:0]             w_conflict_d;
    logic [READ_LATENCY-1:0] r_tag_vld_q;
    logic [READ_LATENCY-1:0] w_tag_vld_d;
    logic [READ_LATENCY-1:0] r_tag_own_q;
    logic [READ_LATENCY-1:0] w_tag_own_d;

    logic w_both;
    logic w_force_i;
    logic w_i_gnt;
    logic w_d_gnt;
    logic w_tail_vld;

    // Data wins ties unless fetch has lost STARVE_LIMIT times in a row.
    always_comb begin
        w_both    = i_req & d_req;
        w_force_i = (r_starve_q == c_STARVE_LIMIT);
        w_d_gnt   = ~rst & d_req & ~(i_req & w_force_i);
        w_i_gnt   = ~rst & i_req & (~d_req | w_force_i);
    end

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = 4'b0000;
        if (w_d_gnt) begin
            m_req   = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
        end else if (w_i_gnt) begin
            m_req  = 1'b1;
            m_addr = i_addr;
            m_be   = 4'b1111;
        end
    end

    always_comb begin
        w_starve_d = r_starve_q;
        if (w_i_gnt || !i_req) begin
            w_starve_d = 4'd0;
        end else if (w_both && w_d_gnt) begin
            w_starve_d = r_starve_q + 4'd1;
        end
    end

    always_comb begin
        w_conflict_d = r_conflict_q;
        if (w_both && (r_conflict_q != c_CNT_MAX)) begin
            w_conflict_d = r_conflict_q + 16'd1;
        end
    end

    // Stage 0 takes the new tag; a flush masks fetch tags as they advance,
    // while a fetch granted alongside the flush enters unmasked.
    always_comb begin
        w_tag_vld_d    = '0;
        w_tag_own_d    = '0;
        w_tag_vld_d[0] = w_i_gnt | (w_d_gnt & ~d_we);
        w_tag_own_d[0] = w_d_gnt;
        for (int k = 1; k < READ_LATENCY; k++) begin
            w_tag_vld_d[k] = r_tag_vld_q[k-1] & ~(i_flush & ~r_tag_own_q[k-1]);
            w_tag_own_d[k] = r_tag_own_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_q   <= 4'd0;
            r_conflict_q <= 16'd0;
            r_tag_vld_q  <= '0;
            r_tag_own_q  <= '0;
        end else begin
            r_starve_q   <= w_starve_d;
            r_conflict_q <= w_conflict_d;
            r_tag_vld_q  <= w_tag_vld_d;
            r_tag_own_q  <= w_tag_own_d;
        end
    end

    assign w_tail_vld   = r_tag_vld_q[c_TAIL] & ~rst;
    assign i_rvalid     = w_tail_vld & ~r_tag_own_q[c_TAIL] & ~i_flush;
    assign d_rvalid     = w_tail_vld & r_tag_own_q[c_TAIL];
    assign i_rdata      = m_rdata;
    assign d_rdata      = m_rdata;
    assign conflict_cnt = r_conflict_q;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported synchronous memory between the CPU's instruction-fetch port and data load/store port, so that a unified RAM can sit behind the 5-stage pipeline. Grants are decided in the same cycle as the request. Data accesses win by default, and an anti-starvation limit guarantees fetch progress. Read data returns after a fixed latency and is steered back to its requester through a tag pipeline; a fetch flush discards stale in-flight fetch responses after a branch or jump redirect.

## Interface
- ADDR_W, 32: address width (matches ALEN)
- DATA_W, 32: data width (matches XLEN)
- READ_LATENCY, 1: memory read latency in cycles, legal range 1..4
- STARVE_LIMIT, 4: consecutive data wins that trigger a forced fetch grant, legal range 1..15
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch read request; held until granted
- i_addr  in  ADDR_W  fetch address
- i_flush  in  1  drop all previously issued, not-yet-returned fetch responses
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request; held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory access this cycle
- m_we  out  1  memory write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  4  memory byte enables
- m_rdata  in  DATA_W  memory read data, valid READ_LATENCY cycles after a read m_req
- conflict_cnt  out  16  saturating count of cycles in which i_req and d_req were both high

## Operation
**Arbitration** (combinational, at most one grant per cycle):
- Only d_req is high: data is granted.
- Only i_req is high: fetch is granted.
- Both are high: data is granted, unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.

**starve_cnt** (4-bit register):
- Increments in each cycle with i_req && d_req && d_gnt.
- Clears in each cycle with i_gnt or !i_req.

**Memory drive when granted:**
- Data grant: m_req=1, m_we=d_we, and m_addr/m_wdata/m_be come from the d_ port.
- Fetch grant: m_req=1, m_we=0, m_be=4'b1111, m_wdata=0.
- No grant: m_req=0, m_we=0, and the other m_* outputs are 0.

**Writes:**
- A store completes at grant.
- A store produces no d_rvalid and no tag.

**Tag pipeline:**
- Each granted read pushes {valid=1, owner} into a READ_LATENCY-deep shift register, with owner 0 = fetch and 1 = data.
- Cycles with no read push valid=0.

**Response steering:**
- The tail entry with owner=fetch asserts i_rvalid.
- The tail entry with owner=data asserts d_rvalid.
- i_rdata and d_rdata both carry m_rdata directly, qualified by their rvalid.

**Flush:**
- i_flush clears valid on every fetch-owned entry already in the pipeline, including the tail, which suppresses i_rvalid that same cycle.
- A fetch granted in the same cycle as i_flush is not flushed.
- Data-owned entries are unaffected by i_flush.

**conflict_cnt:**
- +1 per cycle with i_req && d_req.
- Saturates at 16'hFFFF.

**Reset:**
- While rst is high, i_gnt, d_gnt and m_req are forced to 0.
- At the next edge: tag pipeline cleared, starve_cnt=0, conflict_cnt=0.
- A read in flight when reset asserts never produces an rvalid.

## Timing
- Grant: zero added latency. gnt and the m_* outputs are combinational from the request inputs in the same cycle.
- Read response: i_rvalid/d_rvalid is high exactly READ_LATENCY cycles after the grant edge.
- Throughput: one access per cycle. Back-to-back reads from alternating owners return in issue order with no bubbles.
- Reset values after rst: i_gnt=0, d_gnt=0, i_rvalid=0, d_rvalid=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_be=0, conflict_cnt=0.
  - i_rdata and d_rdata follow m_rdata and are don't-care while their rvalid is 0.
- Requester rule: once req is high, the requester holds req and its payload until gnt. The arbiter does not check this.
- Counter updates:
  - starve_cnt is registered; the forced fetch grant appears in the cycle after the STARVE_LIMIT-th consecutive data win.
  - conflict_cnt updates at the clock edge following the conflict cycle.

## Test plan
- Fetch only, READ_LATENCY=1: i_req with i_addr=0x100 -> i_gnt same cycle, m_addr=0x100, m_we=0; next cycle i_rvalid=1 and i_rdata=m_rdata.
- Contention, STARVE_LIMIT=4: i_req and d_req (load) both held high for 10 cycles -> grant order D,D,D,D,I,D,D,D,D,I; conflict_cnt=10.
- Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> d_gnt, m_we=1, m_be=4'b0011; d_rvalid never asserts for this access.
- Flush, READ_LATENCY=3: fetches granted at cycles 0 and 1, a data load at cycle 2, i_flush at cycle 2 -> no i_rvalid at cycles 3 and 4; d_rvalid=1 at cycle 5.
- Reset with reads in flight, READ_LATENCY=2: rst pulsed one cycle after a fetch grant -> no i_rvalid afterwards; all outputs at reset values; conflict_cnt=0.
- Saturation: i_req and d_req both held high for 65540 cycles -> conflict_cnt=16'hFFFF, with no wrap.
